// File: rtl/req_traffic_gen.sv
// req_traffic_gen: AXI read/write request traffic generator.
// A start pulse launches a run of num_request read (test_case 1..9) or write
// (test_case 10..18) requests. Addresses are base_addr plus a masked,
// 64B-aligned offset taken from a 32-bit Galois LFSR. Responses are counted
// and the block reports done once every request has a response.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start, test_case       run launch pulse and run selector
//   num_request            requests per run
//   base_addr, addr_mask   address region base and random-offset mask
//   seed                   LFSR seed (0 selects 1)
//   m_axi_ar*/r*           read address / read data channels
//   m_axi_aw*/w*/b*        write address / write data / write response channels
//   busy, done             run in progress / sticky run complete
//   issued_cnt             address handshakes this run
//   completed_cnt          R or B handshakes this run
module req_traffic_gen #(
    parameter int unsigned ID_W   = 12,
    parameter int unsigned DATA_W = 512
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [63:0]         test_case,
    input  logic [63:0]         num_request,
    input  logic [63:0]         base_addr,
    input  logic [31:0]         addr_mask,
    input  logic [31:0]         seed,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    output logic [63:0]         m_axi_araddr,
    output logic [ID_W-1:0]     m_axi_arid,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [63:0]         m_axi_awaddr,
    output logic [ID_W-1:0]     m_axi_awid,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic                busy,
    output logic                done,
    output logic [63:0]         issued_cnt,
    output logic [63:0]         completed_cnt
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, WR_ISSUE, WAIT_RESP, DONE, ABORT} state_t;

    // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFC0;

    state_t      state;
    logic [31:0] lfsr;
    logic [31:0] mask_q;
    logic [63:0] tc_q;
    logic [63:0] num_q;
    logic [63:0] base_q;
    logic [63:0] w_addr_q;
    logic        is_wr;

    logic        ar_hs, aw_hs, w_hs, resp_hs;
    logic        tc_rd, tc_wr, tc_changed;
    logic        wr_req_done, abort_clear;
    logic [31:0] lfsr_nx;
    logic [63:0] issued_nx, completed_nx, addr_c, addr_nx;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // Counters saturate so they can never wrap within a run
    function automatic logic [63:0] sat_inc(input logic [63:0] v);
        return (v == '1) ? v : v + 64'd1;
    endfunction

    function automatic logic [63:0] addr_of(input logic [63:0] base, input logic [31:0] mask,
                                            input logic [31:0] v);
        return base + {32'b0, v & mask & ALIGN_MASK};
    endfunction

    // Handshakes and next-value helpers
    always_comb begin
        ar_hs        = m_axi_arvalid & m_axi_arready;
        aw_hs        = m_axi_awvalid & m_axi_awready;
        w_hs         = m_axi_wvalid & m_axi_wready;
        resp_hs      = busy & (is_wr ? m_axi_bvalid : m_axi_rvalid);
        tc_rd        = (test_case >= 64'd1) && (test_case <= 64'd9);
        tc_wr        = (test_case >= 64'd10) && (test_case <= 64'd18);
        tc_changed   = (test_case != tc_q);
        lfsr_nx      = (ar_hs | aw_hs) ? lfsr_step(lfsr) : lfsr;
        issued_nx    = (ar_hs | aw_hs) ? sat_inc(issued_cnt) : issued_cnt;
        completed_nx = resp_hs ? sat_inc(completed_cnt) : completed_cnt;
        addr_c       = addr_of(base_q, mask_q, lfsr);
        addr_nx      = addr_of(base_q, mask_q, lfsr_nx);
        // Both write channels have handshaked for the current request after this edge
        wr_req_done  = (aw_hs | ~m_axi_awvalid) & (w_hs | ~m_axi_wvalid)
                       & (m_axi_awvalid | m_axi_wvalid);
        abort_clear  = ~(m_axi_arvalid & ~ar_hs) & ~(m_axi_awvalid & ~aw_hs)
                       & ~(m_axi_wvalid & ~w_hs);
    end

    // Run control, counters and valids
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            lfsr          <= 32'h1;
            mask_q        <= '0;
            tc_q          <= '0;
            num_q         <= '0;
            base_q        <= '0;
            w_addr_q      <= '0;
            is_wr         <= 1'b0;
            issued_cnt    <= '0;
            completed_cnt <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
        end else begin
            completed_cnt <= completed_nx;
            issued_cnt    <= issued_nx;
            lfsr          <= lfsr_nx;
            if (ar_hs) m_axi_arvalid <= 1'b0;
            if (aw_hs) m_axi_awvalid <= 1'b0;
            if (w_hs)  m_axi_wvalid  <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (state == DONE && tc_changed) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                    if (start && (tc_rd || tc_wr)) begin
                        tc_q          <= test_case;
                        num_q         <= num_request;
                        base_q        <= base_addr;
                        mask_q        <= addr_mask;
                        is_wr         <= tc_wr;
                        lfsr          <= (seed == 32'h0) ? 32'h1 : seed;
                        issued_cnt    <= '0;
                        completed_cnt <= '0;
                        if (num_request == 64'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= tc_wr ? WR_ISSUE : RD_ISSUE;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (tc_changed) begin
                        state <= ABORT;
                    end else if (!m_axi_arvalid) begin
                        m_axi_arvalid <= 1'b1;
                    end else if (ar_hs) begin
                        if (issued_nx >= num_q) begin
                            m_axi_arvalid <= 1'b0;
                            if (completed_nx >= num_q) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= WAIT_RESP;
                            end
                        end else begin
                            m_axi_arvalid <= 1'b1;
                        end
                    end
                end
                WR_ISSUE: begin
                    if (tc_changed) begin
                        state <= ABORT;
                    end else if (!m_axi_awvalid && !m_axi_wvalid) begin
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        w_addr_q      <= addr_c;
                    end else if (wr_req_done) begin
                        if (issued_nx >= num_q) begin
                            if (completed_nx >= num_q) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= WAIT_RESP;
                            end
                        end else begin
                            // W data latches the address so it stays stable after AW moves the LFSR
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            w_addr_q      <= addr_nx;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (tc_changed) begin
                        state <= ABORT;
                    end else if (completed_cnt >= num_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                ABORT: begin
                    if (abort_clear) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_axi_araddr = addr_c;
    assign m_axi_awaddr = addr_c;
    assign m_axi_arid   = ID_W'(issued_cnt[3:0]);
    assign m_axi_awid   = ID_W'(issued_cnt[3:0]);
    assign m_axi_rready = busy;
    assign m_axi_bready = busy;
    assign m_axi_wstrb  = '1;

    // Write data is the 64-bit request address repeated across the bus
    for (genvar i = 0; i < DATA_W; i++) begin : g_wdata
        assign m_axi_wdata[i] = w_addr_q[i % 64];
    end

endmodule

// File: tb/tb_req_traffic_gen.sv
// Directed testbench for req_traffic_gen.
module tb_req_traffic_gen;
    localparam int unsigned ID_W   = 12;
    localparam int unsigned DATA_W = 512;

    logic                clk;
    logic                reset;
    logic                start;
    logic [63:0]         test_case;
    logic [63:0]         num_request;
    logic [63:0]         base_addr;
    logic [31:0]         addr_mask;
    logic [31:0]         seed;
    logic                m_axi_arvalid;
    logic                m_axi_arready;
    logic [63:0]         m_axi_araddr;
    logic [ID_W-1:0]     m_axi_arid;
    logic                m_axi_rvalid;
    logic                m_axi_rready;
    logic                m_axi_awvalid;
    logic                m_axi_awready;
    logic [63:0]         m_axi_awaddr;
    logic [ID_W-1:0]     m_axi_awid;
    logic                m_axi_wvalid;
    logic                m_axi_wready;
    logic [DATA_W-1:0]   m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic                m_axi_bvalid;
    logic                m_axi_bready;
    logic                busy;
    logic                done;
    logic [63:0]         issued_cnt;
    logic [63:0]         completed_cnt;

    int checks;
    int failures;

    req_traffic_gen #(.ID_W(ID_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .start(start), .test_case(test_case),
        .num_request(num_request), .base_addr(base_addr), .addr_mask(addr_mask), .seed(seed),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .busy(busy), .done(done), .issued_cnt(issued_cnt), .completed_cnt(completed_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic [63:0] tc, input logic [63:0] num,
                               input logic [63:0] base, input logic [31:0] mask,
                               input logic [31:0] sd);
        test_case   = tc;
        num_request = num;
        base_addr   = base;
        addr_mask   = mask;
        seed        = sd;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid} !== 3'b000) begin
            failures++; $display("FAIL reset_valids: got %b expected 000", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}); end
        checks++; if ({m_axi_rready, m_axi_bready, busy, done} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: got %b expected 0000", {m_axi_rready, m_axi_bready, busy, done}); end
        checks++; if (issued_cnt !== 64'd0 || completed_cnt !== 64'd0) begin
            failures++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", issued_cnt, completed_cnt); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_basic();
        logic [63:0] exp_addr [4];
        int k, first_c, last_c, w;
        exp_addr = '{64'h0, 64'h8020_0000, 64'hC030_0000, 64'h6018_0000};
        m_axi_arready = 1'b1;
        pulse_start(64'd1, 64'd4, 64'd0, 32'hFFFF_FFFF, 32'd1);
        k = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 20; c++) begin
            if (m_axi_arvalid) begin
                if (k < 4) begin
                    checks++; if (m_axi_araddr !== exp_addr[k]) begin
                        failures++; $display("FAIL rd_addr[%0d]: got %h expected %h", k, m_axi_araddr, exp_addr[k]); end
                    checks++; if (m_axi_arid !== ID_W'(k)) begin
                        failures++; $display("FAIL rd_id[%0d]: got %0d expected %0d", k, m_axi_arid, k); end
                end
                if (k == 0) first_c = c;
                last_c = c;
                k++;
            end
            @(negedge clk);
        end
        m_axi_arready = 1'b0;
        checks++; if (k !== 4) begin
            failures++; $display("FAIL rd_beats: got %0d expected 4", k); end
        checks++; if (last_c - first_c !== 3) begin
            failures++; $display("FAIL rd_back_to_back: got span %0d expected 3", last_c - first_c); end
        checks++; if (issued_cnt !== 64'd4 || busy !== 1'b1) begin
            failures++; $display("FAIL rd_issued: got %0d busy %b expected 4 busy 1", issued_cnt, busy); end
        m_axi_rvalid = 1'b1;
        repeat (4) @(negedge clk);
        m_axi_rvalid = 1'b0;
        w = 0;
        while (!done && w < 10) begin @(negedge clk); w++; end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL rd_done: got done %b busy %b expected 1 0", done, busy); end
        checks++; if (completed_cnt !== 64'd4) begin
            failures++; $display("FAIL rd_completed: got %0d expected 4", completed_cnt); end
    endtask

    task automatic test_write_stall();
        int w;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b0;
        pulse_start(64'd10, 64'd2, 64'h1000, 32'hFFFF_FFFF, 32'd1);
        w = 0;
        while (!m_axi_awvalid && w < 10) begin @(negedge clk); w++; end
        checks++; if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1) begin
            failures++; $display("FAIL wr_first_valids: got aw %b w %b expected 1 1", m_axi_awvalid, m_axi_wvalid); end
        checks++; if (m_axi_awaddr !== 64'h1000 || m_axi_awid !== ID_W'(0)) begin
            failures++; $display("FAIL wr_first_addr: got %h id %0d expected 1000 id 0", m_axi_awaddr, m_axi_awid); end
        checks++; if (m_axi_wdata[63:0] !== 64'h1000 || m_axi_wdata[DATA_W-1 -: 64] !== 64'h1000) begin
            failures++; $display("FAIL wr_first_data: got %h/%h expected 1000", m_axi_wdata[63:0], m_axi_wdata[DATA_W-1 -: 64]); end
        checks++; if (m_axi_wstrb !== {(DATA_W/8){1'b1}}) begin
            failures++; $display("FAIL wr_strb: got %h expected all ones", m_axi_wstrb); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b1 || m_axi_wdata[63:0] !== 64'h1000) begin
                failures++; $display("FAIL wr_stall[%0d]: got aw %b w %b data %h expected 0 1 1000",
                                     i, m_axi_awvalid, m_axi_wvalid, m_axi_wdata[63:0]); end
        end
        m_axi_wready = 1'b1;
        @(negedge clk);
        checks++; if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1) begin
            failures++; $display("FAIL wr_second_valids: got aw %b w %b expected 1 1", m_axi_awvalid, m_axi_wvalid); end
        checks++; if (m_axi_awaddr !== 64'h8020_1000 || m_axi_awid !== ID_W'(1)) begin
            failures++; $display("FAIL wr_second_addr: got %h id %0d expected 80201000 id 1", m_axi_awaddr, m_axi_awid); end
        checks++; if (m_axi_wdata[127:64] !== 64'h8020_1000) begin
            failures++; $display("FAIL wr_second_data: got %h expected 80201000", m_axi_wdata[127:64]); end
        @(negedge clk);
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        checks++; if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || issued_cnt !== 64'd2) begin
            failures++; $display("FAIL wr_issue_end: got aw %b w %b issued %0d expected 0 0 2",
                                 m_axi_awvalid, m_axi_wvalid, issued_cnt); end
        m_axi_bvalid = 1'b1;
        repeat (2) @(negedge clk);
        m_axi_bvalid = 1'b0;
        w = 0;
        while (!done && w < 10) begin @(negedge clk); w++; end
        checks++; if (done !== 1'b1 || completed_cnt !== 64'd2) begin
            failures++; $display("FAIL wr_done: got done %b completed %0d expected 1 2", done, completed_cnt); end
    endtask

    task automatic test_zero_requests();
        pulse_start(64'd1, 64'd0, 64'd0, 32'hFFFF_FFFF, 32'd1);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL zero_done: got done %b busy %b expected 1 0", done, busy); end
        for (int i = 0; i < 4; i++) begin
            checks++; if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid} !== 3'b000) begin
                failures++; $display("FAIL zero_no_valid[%0d]: got %b expected 000", i,
                                     {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}); end
            @(negedge clk);
        end
        test_case = 64'd5;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin
            failures++; $display("FAIL done_clear_on_tc: got %b expected 0", done); end
    endtask

    task automatic test_id_wrap();
        int k, rsent;
        m_axi_arready = 1'b1;
        pulse_start(64'd1, 64'd20, 64'h4000, 32'h0000_FFFF, 32'd5);
        k = 0; rsent = 0;
        for (int c = 0; c < 80; c++) begin
            if (m_axi_arvalid) begin
                checks++; if (m_axi_arid !== ID_W'(k % 16)) begin
                    failures++; $display("FAIL wrap_id[%0d]: got %0d expected %0d", k, m_axi_arid, k % 16); end
                k++;
            end
            if (done) break;
            m_axi_rvalid = (rsent < 20);
            if (m_axi_rvalid) rsent++;
            @(negedge clk);
        end
        m_axi_rvalid  = 1'b0;
        m_axi_arready = 1'b0;
        checks++; if (k !== 20) begin
            failures++; $display("FAIL wrap_beats: got %0d expected 20", k); end
        checks++; if (issued_cnt !== 64'd20 || completed_cnt !== 64'd20) begin
            failures++; $display("FAIL wrap_counts: got %0d/%0d expected 20/20", issued_cnt, completed_cnt); end
        checks++; if (done !== 1'b1) begin
            failures++; $display("FAIL wrap_done: got %b expected 1", done); end
    endtask

    task automatic test_abort();
        int w;
        m_axi_arready = 1'b0;
        pulse_start(64'd1, 64'd4, 64'd0, 32'hFFFF_FFFF, 32'd1);
        w = 0;
        while (!m_axi_arvalid && w < 10) begin @(negedge clk); w++; end
        checks++; if (m_axi_arvalid !== 1'b1) begin
            failures++; $display("FAIL abort_arvalid_up: got %b expected 1", m_axi_arvalid); end
        test_case = 64'd2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h0 || busy !== 1'b1) begin
                failures++; $display("FAIL abort_hold[%0d]: got v %b addr %h busy %b expected 1 0 1",
                                     i, m_axi_arvalid, m_axi_araddr, busy); end
        end
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        checks++; if (m_axi_arvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_idle: got v %b busy %b done %b expected 0 0 0",
                                 m_axi_arvalid, busy, done); end
        checks++; if (issued_cnt !== 64'd1) begin
            failures++; $display("FAIL abort_issued: got %0d expected 1", issued_cnt); end
        @(negedge clk);
        checks++; if (m_axi_arvalid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_stays_idle: got v %b busy %b expected 0 0", m_axi_arvalid, busy); end
    endtask

    task automatic test_ignored_start();
        pulse_start(64'd0, 64'd3, 64'd0, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        checks++; if (busy !== 1'b0 || m_axi_arvalid !== 1'b0 || m_axi_awvalid !== 1'b0) begin
            failures++; $display("FAIL ignore_tc0: got busy %b ar %b aw %b expected 0 0 0",
                                 busy, m_axi_arvalid, m_axi_awvalid); end
        pulse_start(64'd19, 64'd3, 64'd0, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        checks++; if (busy !== 1'b0 || m_axi_awvalid !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL ignore_tc19: got busy %b aw %b done %b expected 0 0 0",
                                 busy, m_axi_awvalid, done); end
    endtask

    task automatic test_reset_mid_write();
        int w;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        pulse_start(64'd10, 64'd8, 64'd0, 32'hFFFF_FFFF, 32'd3);
        w = 0;
        while (!m_axi_awvalid && w < 10) begin @(negedge clk); w++; end
        checks++; if (busy !== 1'b1 || m_axi_awvalid !== 1'b1) begin
            failures++; $display("FAIL midrst_pre: got busy %b aw %b expected 1 1", busy, m_axi_awvalid); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready, busy, done} !== 7'b0) begin
            failures++; $display("FAIL midrst_flags: got %b expected 0000000",
                                 {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready, busy, done}); end
        checks++; if (issued_cnt !== 64'd0 || completed_cnt !== 64'd0) begin
            failures++; $display("FAIL midrst_counters: got %0d/%0d expected 0/0", issued_cnt, completed_cnt); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        start         = 1'b0;
        test_case     = '0;
        num_request   = '0;
        base_addr     = '0;
        addr_mask     = '0;
        seed          = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        @(negedge clk);
        test_reset();
        test_read_basic();
        test_write_stall();
        test_zero_requests();
        test_id_wrap();
        test_abort();
        test_ignored_start();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/req_traffic_gen.md
REQ_TRAFFIC_GEN -- requirements
Module: req_traffic_gen

Interface
REQ-001 Parameter ID_W, default 12, AXI ID width; SHALL be at least 4.
REQ-002 Parameter DATA_W, default 512, AXI data width; SHALL be a multiple of 8.
REQ-003 Ports SHALL be:
- clk  in  1  sole clock; one clock; all logic on posedge clk.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; launches a run.
- test_case  in  64  1..9 read run; 10..18 write run; other values issue no traffic.
- num_request  in  64  requests per run.
- base_addr  in  64  region base, 64B aligned.
- addr_mask  in  32  random-offset mask, applied before alignment.
- seed  in  32  LFSR seed.
- m_axi_arvalid, m_axi_arready  out/in  1  AR handshake.
- m_axi_araddr  out  64  read address.
- m_axi_arid  out  ID_W  read ID.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.
- m_axi_awvalid, m_axi_awready  out/in  1  AW handshake.
- m_axi_awaddr  out  64  write address.
- m_axi_awid  out  ID_W  write ID.
- m_axi_wvalid, m_axi_wready  out/in  1  W handshake.
- m_axi_wdata  out  DATA_W  write data.
- m_axi_wstrb  out  DATA_W/8  write strobes.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- busy  out  1  run in progress.
- done  out  1  sticky run complete.
- issued_cnt  out  64  address handshakes this run.
- completed_cnt  out  64  R/B handshakes this run.

Function
REQ-004 States SHALL be IDLE, RD_ISSUE, WR_ISSUE, WAIT_RESP, DONE and ABORT.
REQ-005 IDLE/DONE + start with test_case 1..9 SHALL go to RD_ISSUE.
REQ-006 IDLE/DONE + start with test_case 10..18 SHALL go to WR_ISSUE.
REQ-007 Start with any other test_case SHALL be ignored.
REQ-008 On start, issued_cnt, completed_cnt and done SHALL clear, and the LFSR SHALL load seed, or 32'h1 if seed is 0.
REQ-009 Start with num_request==0 SHALL go directly to DONE the next cycle with no valid asserted.
REQ-010 The LFSR SHALL be a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, and SHALL advance exactly once per address handshake.
REQ-011 Address SHALL be base_addr + {32'b0, (lfsr & addr_mask) & 32'hFFFF_FFC0}, computed combinationally from the current LFSR value and held stable while valid.
REQ-012 Request k (0-based) SHALL carry ID = k mod 16, zero-extended to ID_W.
REQ-013 RD_ISSUE: arvalid SHALL assert the cycle after entry, next request presented on the cycle following each handshake (back-to-back), until issued_cnt==num_request, then go to WAIT_RESP.
REQ-014 WR_ISSUE: awvalid and wvalid SHALL assert together per request.
REQ-015 WR_ISSUE: each write channel SHALL deassert independently after its own handshake; the next request SHALL start only after both channels have handshaked.
REQ-016 wdata SHALL be the 64-bit address replicated; wstrb SHALL be all ones.
REQ-017 rready and bready SHALL be 1 whenever busy.
REQ-018 Responses SHALL be counted in any state including the issue states; completed_cnt SHALL increment on each R (read run) or B (write run) handshake.
REQ-019 WAIT_RESP SHALL go to DONE on the cycle after completed_cnt reaches num_request; if this occurs during issue, the block SHALL go to DONE after the last address handshake.
REQ-020 DONE: busy=0; done=1 held until start, test_case change, or reset.
REQ-021 A valid, once asserted, SHALL stay asserted with stable payload until its handshake (AXI rule).
REQ-022 A change of test_case while busy SHALL enter ABORT: no new valids, pending valids held until handshake, then IDLE with done=0.
REQ-023 Counters SHALL be 64-bit and SHALL not wrap within a run.

Reset
REQ-024 reset SHALL force IDLE; all valids, rready, bready, busy and done =0; counters =0; LFSR =32'h1.
REQ-025 Reset mid-run SHALL take effect the next edge regardless of pending handshakes.

Verification
REQ-026 seed=1, mask=FFFF_FFFF, base=0, tc=1, num=4, arready=1 -> 4 AR beats on consecutive cycles, IDs 0,1,2,3, addresses match the LFSR model; 4 R beats -> done=1.
REQ-027 tc=10, num=2, awready=1, wready stalled 3 cycles -> wvalid held with stable data, second AW only after the first W handshake; 2 B beats -> done.
REQ-028 num=0, start -> DONE next cycle, no valid ever asserted.
REQ-029 tc=1, num=20 -> arid wraps 15->0 at request 16; issued_cnt=20, completed_cnt=20.
REQ-030 tc changes 1->2 while arvalid=1 and arready=0 -> arvalid held until handshake, then IDLE, done=0.
REQ-031 Reset asserted mid-write-run -> next cycle all outputs at reset values.
